// File: rtl/magic_seq_pkg.sv
// Shared definitions for the magic sequencer register space: field indices,
// AXI response codes, read FSM states and the per-field width lookup.
package magic_seq_pkg;

  localparam int BANK1_SRC_ADDR_WIDTH = 32;
  localparam int BANK1_SRC_SIZE_WIDTH = 26;
  localparam int BANK1_DST_ADDR_WIDTH = 32;
  localparam int BANK1_DST_SIZE_WIDTH = 26;
  localparam int BANK1_STATUS_WIDTH   = 2;
  localparam int BANK1_PROFILE_WIDTH  = 32;
  localparam int BANK1_LD_MSK_WIDTH   = 8;
  localparam int BANK1_ST_MSK_WIDTH   = 8;
  localparam int BANK0_CONTROL_WIDTH  = 4;
  localparam int BANK0_STATUS_WIDTH   = 4;
  localparam int BANK0_CNT_WIDTH      = 3;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam logic [2:0] FLD_SRC_ADDR = 3'd0;
  localparam logic [2:0] FLD_SRC_SIZE = 3'd1;
  localparam logic [2:0] FLD_DST_ADDR = 3'd2;
  localparam logic [2:0] FLD_DST_SIZE = 3'd3;
  localparam logic [2:0] FLD_STATUS   = 3'd4;
  localparam logic [2:0] FLD_PROFILE  = 3'd5;
  localparam logic [2:0] FLD_LD_MSK   = 3'd6;
  localparam logic [2:0] FLD_ST_MSK   = 3'd7;
  localparam logic [2:0] FLD_CTRL     = 3'd0;
  localparam logic [2:0] FLD_STAT     = 3'd1;
  localparam logic [2:0] FLD_CNT      = 3'd2;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } rd_state_t;

  // Width 0 marks a field that does not exist.
  function automatic int fld_width(input logic bank, input logic [2:0] field);
    int w;
    w = 0;
    if (bank == BANK1) begin
      case (field)
        FLD_SRC_ADDR: w = BANK1_SRC_ADDR_WIDTH;
        FLD_SRC_SIZE: w = BANK1_SRC_SIZE_WIDTH;
        FLD_DST_ADDR: w = BANK1_DST_ADDR_WIDTH;
        FLD_DST_SIZE: w = BANK1_DST_SIZE_WIDTH;
        FLD_STATUS:   w = BANK1_STATUS_WIDTH;
        FLD_PROFILE:  w = BANK1_PROFILE_WIDTH;
        FLD_LD_MSK:   w = BANK1_LD_MSK_WIDTH;
        FLD_ST_MSK:   w = BANK1_ST_MSK_WIDTH;
        default:      w = 0;
      endcase
    end else begin
      case (field)
        FLD_CTRL: w = BANK0_CONTROL_WIDTH;
        FLD_STAT: w = BANK0_STATUS_WIDTH;
        FLD_CNT:  w = BANK0_CNT_WIDTH;
        default:  w = 0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/s_axi_rd_decode.sv
// Combinational read-address decode: bank/slot/field, legality and the
// zero-extension mask for the addressed field.
module s_axi_rd_decode
  import magic_seq_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH   = 32,
  parameter int GLOB_DATA_WIDTH   = 32,
  parameter int BANK1_INDEX_WIDTH = 3
) (
  input  logic [GLOB_ADDR_WIDTH-1:0]   i_addr,
  output logic                         o_bank,
  output logic [BANK1_INDEX_WIDTH-1:0] o_slot,
  output logic [2:0]                   o_field,
  output logic                         o_valid,
  output logic [GLOB_DATA_WIDTH-1:0]   o_mask
);

  logic                         w_sel_bank0;
  logic [BANK1_INDEX_WIDTH-1:0] w_slot_raw;
  logic                         w_upper_zero;
  logic                         w_unused_lsb;
  int                           w_width;

  // The bank-select address bit set addresses bank0; clear addresses bank1.
  assign w_sel_bank0  = i_addr[5+BANK1_INDEX_WIDTH];
  assign w_slot_raw   = i_addr[4+BANK1_INDEX_WIDTH:5];
  assign w_upper_zero = (i_addr[GLOB_ADDR_WIDTH-1:6+BANK1_INDEX_WIDTH] == '0);
  assign w_unused_lsb = ^i_addr[1:0];

  assign o_field = i_addr[4:2];
  assign o_bank  = w_sel_bank0 ? BANK0 : BANK1;
  assign o_slot  = w_sel_bank0 ? '0 : w_slot_raw;
  assign o_valid = w_upper_zero &&
                   (!w_sel_bank0 || ((w_slot_raw == '0) && (o_field <= FLD_CNT)));

  always_comb begin
    w_width = fld_width(o_bank, o_field);
    if (w_width >= GLOB_DATA_WIDTH) o_mask = '1;
    else                            o_mask = (GLOB_DATA_WIDTH'(1) << w_width) - GLOB_DATA_WIDTH'(1);
  end

endmodule

// File: rtl/s_axi_read_slave.sv
// AXI4-Lite read responder for the magic sequencer register space.
// Define MAGIC_SEQ_RD_SLVERR_EN to answer illegal addresses with SLVERR.
module s_axi_read_slave
  import magic_seq_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH   = 32,
  parameter int GLOB_DATA_WIDTH   = 32,
  parameter int BANK1_INDEX_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [GLOB_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [GLOB_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic                         reg_rd_en,
  output logic                         reg_rd_bank,
  output logic [BANK1_INDEX_WIDTH-1:0] reg_rd_slot,
  output logic [2:0]                   reg_rd_field,
  input  logic [GLOB_DATA_WIDTH-1:0]   reg_rd_data
);

`ifdef MAGIC_SEQ_RD_SLVERR_EN
  localparam logic [1:0] INVALID_RESP = RRESP_SLVERR;
`else
  localparam logic [1:0] INVALID_RESP = RRESP_OKAY;
`endif

  rd_state_t                    r_state, w_state_nxt;
  logic                         w_arready, w_rd_en, w_load_r;
  logic                         w_dec_bank, w_dec_valid;
  logic [BANK1_INDEX_WIDTH-1:0] w_dec_slot;
  logic [2:0]                   w_dec_field;
  logic [GLOB_DATA_WIDTH-1:0]   w_dec_mask;

  logic                         r_bank, r_valid;
  logic [BANK1_INDEX_WIDTH-1:0] r_slot;
  logic [2:0]                   r_field;
  logic [GLOB_DATA_WIDTH-1:0]   r_mask;
  logic                         r_rvalid;
  logic [GLOB_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                   r_rresp;

  s_axi_rd_decode #(
    .GLOB_ADDR_WIDTH  (GLOB_ADDR_WIDTH),
    .GLOB_DATA_WIDTH  (GLOB_DATA_WIDTH),
    .BANK1_INDEX_WIDTH(BANK1_INDEX_WIDTH)
  ) u_decode (
    .i_addr (S_AXI_ARADDR),
    .o_bank (w_dec_bank),
    .o_slot (w_dec_slot),
    .o_field(w_dec_field),
    .o_valid(w_dec_valid),
    .o_mask (w_dec_mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ARREADY is gated by reset so it drops the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_rd_en     = 1'b0;
    w_load_r    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arready = reset;
        if (S_AXI_ARVALID && w_arready) w_state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        w_rd_en     = r_valid;
        w_load_r    = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_rvalid && S_AXI_RREADY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bank  <= BANK0;
      r_slot  <= '0;
      r_field <= '0;
      r_valid <= 1'b0;
      r_mask  <= '0;
    end else if (S_AXI_ARVALID && w_arready) begin
      r_bank  <= w_dec_bank;
      r_slot  <= w_dec_slot;
      r_field <= w_dec_field;
      r_valid <= w_dec_valid;
      r_mask  <= w_dec_mask;
    end
  end

  // Storage data arrives during LOOKUP and is captured on the edge leaving it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RRESP_OKAY;
    end else if (w_load_r) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_valid ? (reg_rd_data & r_mask) : '0;
      r_rresp  <= r_valid ? RRESP_OKAY : INVALID_RESP;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_rd_en     = w_rd_en;
  assign reg_rd_bank   = r_bank;
  assign reg_rd_slot   = r_slot;
  assign reg_rd_field  = r_field;

endmodule

// File: tb/tb_s_axi_read_slave.sv
// Directed bench for s_axi_read_slave: decode, masking, backpressure,
// illegal addresses and asynchronous reset in the middle of a transaction.
module tb_s_axi_read_slave;

  logic        clk;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rd_en;
  logic        rd_bank;
  logic [2:0]  rd_slot;
  logic [2:0]  rd_field;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MAGIC_SEQ_RD_SLVERR_EN
  localparam logic [1:0] BAD_RESP = 2'b10;
`else
  localparam logic [1:0] BAD_RESP = 2'b00;
`endif

  s_axi_read_slave dut (
    .clk          (clk),
    .reset        (reset),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .reg_rd_en    (rd_en),
    .reg_rd_bank  (rd_bank),
    .reg_rd_slot  (rd_slot),
    .reg_rd_field (rd_field),
    .reg_rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, req);
    end
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input int hold, input logic exp_en, input logic exp_bank,
                         input logic [2:0] exp_slot, input logic [2:0] exp_field,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_rresp);
    chk({tag, "/arready_idle"}, 32'(arready), 32'd1);
    araddr  = addr;
    arvalid = 1'b1;
    rd_data = data;
    rready  = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    araddr  = 32'h0;
    chk({tag, "/rd_en"}, 32'(rd_en), 32'(exp_en));
    if (exp_en) begin
      chk({tag, "/rd_bank"},  32'(rd_bank),  32'(exp_bank));
      chk({tag, "/rd_slot"},  32'(rd_slot),  32'(exp_slot));
      chk({tag, "/rd_field"}, 32'(rd_field), 32'(exp_field));
    end
    chk({tag, "/arready_lookup"}, 32'(arready), 32'd0);
    chk({tag, "/rvalid_lookup"},  32'(rvalid),  32'd0);
    rready = (hold == 0);
    @(posedge clk); #1;
    chk({tag, "/rvalid"},  32'(rvalid),  32'd1);
    chk({tag, "/rdata"},   rdata,        exp_rdata);
    chk({tag, "/rresp"},   32'(rresp),   32'(exp_rresp));
    chk({tag, "/rd_en_resp"}, 32'(rd_en), 32'd0);
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "/rvalid_hold"},  32'(rvalid),  32'd1);
        chk({tag, "/rdata_hold"},   rdata,        exp_rdata);
        chk({tag, "/rresp_hold"},   32'(rresp),   32'(exp_rresp));
        chk({tag, "/arready_hold"}, 32'(arready), 32'd0);
      end
      rready = 1'b1;
    end
    @(posedge clk); #1;
    rready = 1'b0;
    chk({tag, "/rvalid_done"},  32'(rvalid),  32'd0);
    chk({tag, "/arready_done"}, 32'(arready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    araddr  = 32'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
    rd_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/arready", 32'(arready), 32'd0);
    chk("rst/rvalid",  32'(rvalid),  32'd0);
    chk("rst/rdata",   rdata,        32'd0);
    chk("rst/rresp",   32'(rresp),   32'd0);
    chk("rst/rd_en",   32'(rd_en),   32'd0);
    reset = 1'b1;
    #1;
    chk("rel/arready", 32'(arready), 32'd1);
    @(posedge clk); #1;

    do_read("b1s2f1",   32'h0000_0044, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 3'd2, 3'd1, 32'h03FF_FFFF, 2'b00);
    do_read("lsb_ign",  32'h0000_0047, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 3'd2, 3'd1, 32'h03FF_FFFF, 2'b00);
    do_read("bp5",      32'h0000_0044, 32'hFFFF_FFFF, 5, 1'b1, 1'b1, 3'd2, 3'd1, 32'h03FF_FFFF, 2'b00);
    do_read("b0cnt",    32'h0000_0108, 32'hABCD_EF05, 0, 1'b1, 1'b0, 3'd0, 3'd2, 32'h0000_0005, 2'b00);
    do_read("b0ctrl",   32'h0000_0100, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_000F, 2'b00);
    do_read("b1s7f7",   32'h0000_00FC, 32'h1234_5678, 0, 1'b1, 1'b1, 3'd7, 3'd7, 32'h0000_0078, 2'b00);
    do_read("b1s3stat", 32'h0000_0070, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 3'd3, 3'd4, 32'h0000_0003, 2'b00);
    do_read("b1prof",   32'h0000_0014, 32'hDEAD_BEEF, 0, 1'b1, 1'b1, 3'd0, 3'd5, 32'hDEAD_BEEF, 2'b00);
    do_read("inv_f3",   32'h0000_010C, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, BAD_RESP);
    do_read("inv_slot", 32'h0000_0120, 32'hFFFF_FFFF, 2, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, BAD_RESP);
    do_read("inv_b9",   32'h0000_0244, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, BAD_RESP);
    do_read("inv_b31",  32'h8000_0044, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0000, BAD_RESP);

    // Reset while the response beat is waiting.
    araddr  = 32'h0000_0044;
    rd_data = 32'hFFFF_FFFF;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    chk("mid/rvalid_pre", 32'(rvalid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid/rvalid",  32'(rvalid),  32'd0);
    chk("mid/rdata",   rdata,        32'd0);
    chk("mid/rresp",   32'(rresp),   32'd0);
    chk("mid/arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid/arready_rel", 32'(arready), 32'd1);
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid/no_stale", 32'(rvalid), 32'd0);
    end
    rready = 1'b0;
    do_read("mid_fresh", 32'h0000_00FC, 32'h1234_5678, 0, 1'b1, 1'b1, 3'd7, 3'd7, 32'h0000_0078, 2'b00);

    // Reset while the storage lookup is in flight.
    araddr  = 32'h0000_0108;
    rd_data = 32'hABCD_EF05;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("lk/rd_en_pre", 32'(rd_en), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("lk/rd_en", 32'(rd_en), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("lk/no_beat", 32'(rvalid),  32'd0);
      chk("lk/idle",    32'(arready), 32'd1);
    end
    do_read("lk_fresh", 32'h0000_0108, 32'hABCD_EF05, 0, 1'b1, 1'b0, 3'd0, 3'd2, 32'h0000_0005, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
